blink_boot_ctrl: RTL and testbench

Parametrised multi-channel LED blinker with an integrated warm-boot sequencer for iCE40 designs. A shared prescaler drives NUM_CH LED channels, each toggling at its own integer fraction of the base rate. After a programmable number of base ticks, or on an external request, an FSM holds a visible "leaving" pattern and then asserts the warm-boot request with a compile-time image select. It sits at the top level, beside the board LED pins and the `SB_WARMBOOT` primitive.

---
 rtl/blink_pkg.sv | 16 +
 rtl/blink_channel.sv | 53 +++++
 rtl/blink_boot_ctrl.sv | 138 +++++++++++++
 tb/tb_blink_boot_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and constants for the multi-channel blinker / warm-boot sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package blink_pkg;

   // Sequencer states; the encoding is exported unchanged on the STATE port.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_BOOT = 2'd2
   } state_t;

   // Default warm-boot image select, {S1,S0}.
   localparam logic [1:0] BOOT_IMAGE_DEF = 2'b10;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: toggles its LED once every DIV base ticks while enabled.
// Latency: LED changes on the edge that consumes the DIV-th tick; enable clears on the next edge.
// Backpressure: none; freeze holds phase and LED unchanged.
//
// Ports: CLK/RST (sync, active-high), tick (shared prescaler strobe),
//        enable (per-channel blink enable), freeze (hold phase), led (registered).
module blink_channel #(
   parameter int DIV = 1,
   parameter int PW  = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic tick,
   input  logic enable,
   input  logic freeze,
   output logic led
);

   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

   logic [PW-1:0] phase_q, phase_d;
   logic          led_q,   led_d;

   always_comb begin
      phase_d = phase_q;
      led_d   = led_q;
      if (!enable) begin
         // Disabled channels go dark and restart counting from phase 0.
         phase_d = '0;
         led_d   = 1'b0;
      end else if (tick && !freeze) begin
         if (phase_q == PH_LAST) begin
            phase_d = '0;
            led_d   = ~led_q;
         end else begin
            phase_d = phase_q + PW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         phase_q <= '0;
         led_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/blink_boot_ctrl.sv
// Multi-channel LED blinker with warm-boot sequencer (RUN -> HOLD -> BOOT).
// Latency: BOOT_REQ -> STATE=HOLD one edge; HOLD -> BOOT after HOLD_CYCLES edges; no input-to-output comb paths.
// Backpressure: none; BOOT is terminal until RST.
//
// Ports: CLK, RST (sync, active-high), EN_CH[NUM_CH] blink enables, BOOT_REQ (level),
//        LED[NUM_CH], STATE (0 RUN / 1 HOLD / 2 BOOT), BOOT_O (registered), SEL_O (= BOOT_IMAGE).
// Build option: define BLINK_WARMBOOT_EN to instantiate SB_WARMBOOT driven by BOOT_O/SEL_O.
module blink_boot_ctrl
   import blink_pkg::*;
#(
   parameter int         NUM_CH       = 3,
   parameter int         LOG2DELAY    = 22,
   parameter int         BOOT_TOGGLES = 16,
   parameter int         HOLD_CYCLES  = 1024,
   parameter logic [1:0] BOOT_IMAGE   = BOOT_IMAGE_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] EN_CH,
   input  logic              BOOT_REQ,
   output logic [NUM_CH-1:0] LED,
   output logic [1:0]        STATE,
   output logic              BOOT_O,
   output logic [1:0]        SEL_O
);

   localparam int PW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BCW     = (BOOT_TOGGLES > 0) ? $clog2(BOOT_TOGGLES + 1) : 1;
   // A hold length of 0 would skip HOLD entirely; stretch it to one cycle.
   localparam int HCE     = (HOLD_CYCLES > 0) ? HOLD_CYCLES : 1;
   localparam int HCW     = $clog2(HCE + 1);
   localparam bit AUTO_EN = (BOOT_TOGGLES != 0);

   localparam logic [BCW-1:0] BC_LAST = BCW'(BOOT_TOGGLES - 1);
   localparam logic [HCW-1:0] HC_LAST = HCW'(HCE - 1);

   logic [LOG2DELAY-1:0] presc_q,  presc_d;
   logic [BCW-1:0]       bcnt_q,   bcnt_d;
   logic [HCW-1:0]       hold_q,   hold_d;
   state_t               state_q,  state_d;
   logic                 boot_o_q, boot_o_d;

   logic                 tick;
   logic                 freeze;
   logic [NUM_CH-1:0]    ch_led;
   logic [NUM_CH-1:0]    led_mux;

   // Tick is high during the all-ones cycle so updates land on the wrapping edge.
   assign tick   = &presc_q;
   assign freeze = (state_q != ST_RUN);

   always_comb begin
      presc_d = presc_q + LOG2DELAY'(1);
      bcnt_d  = bcnt_q;
      hold_d  = hold_q;
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (tick) begin
               bcnt_d = bcnt_q + BCW'(1);
            end
            // Request and auto-boot on the same edge collapse into one entry.
            if (BOOT_REQ || (AUTO_EN && tick && (bcnt_q == BC_LAST))) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == HC_LAST) begin
               state_d = ST_BOOT;
            end else begin
               hold_d = hold_q + HCW'(1);
            end
         end
         ST_BOOT: begin
            state_d = ST_BOOT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      boot_o_d = (state_d == ST_BOOT);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         presc_q  <= '0;
         bcnt_q   <= '0;
         hold_q   <= '0;
         state_q  <= ST_RUN;
         boot_o_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         bcnt_q   <= bcnt_d;
         hold_q   <= hold_d;
         state_q  <= state_d;
         boot_o_q <= boot_o_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      blink_channel #(
         .DIV (i + 1),
         .PW  (PW)
      ) u_ch (
         .CLK    (CLK),
         .RST    (RST),
         .tick   (tick),
         .enable (EN_CH[i]),
         .freeze (freeze),
         .led    (ch_led[i])
      );
   end

   // Selector driven only by flops (state register and channel LED registers).
   always_comb begin
      case (state_q)
         ST_HOLD: led_mux = '1;
         ST_BOOT: led_mux = '0;
         default: led_mux = ch_led;
      endcase
   end

   assign LED    = led_mux;
   assign STATE  = state_q;
   assign BOOT_O = boot_o_q;
   assign SEL_O  = BOOT_IMAGE;

`ifdef BLINK_WARMBOOT_EN
   SB_WARMBOOT u_warmboot (
      .BOOT (BOOT_O),
      .S1   (SEL_O[1]),
      .S0   (SEL_O[0])
   );
`else
   // No primitive: BOOT_O/SEL_O are exported for an external warm-boot block.
`endif

endmodule

// File: tb/tb_blink_boot_ctrl.sv
// Bench for blink_boot_ctrl: vector table plus scoreboard queue, two instances
// (auto-boot after 5 ticks, and auto-boot disabled) sharing clock and inputs.
// Hand-written sequences cover reset inside HOLD and inside BOOT.
module tb_blink_boot_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] en_ch;
   logic       boot_req;

   logic [2:0] led_a, led_b;
   logic [1:0] st_a, st_b, sel_a, sel_b;
   logic       boot_a, boot_b;

   int edge_n   = 0;
   int n_checks = 0;
   int n_err    = 0;

   localparam logic [1:0] SEL_EXP = 2'b10;

   always #5 clk = ~clk;

   // Edge numbering restarts at 0 on each edge that samples reset high.
   always @(posedge clk) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   blink_boot_ctrl #(
      .NUM_CH(3), .LOG2DELAY(4), .BOOT_TOGGLES(5), .HOLD_CYCLES(8), .BOOT_IMAGE(2'b10)
   ) dut_a (
      .CLK(clk), .RST(rst), .EN_CH(en_ch), .BOOT_REQ(boot_req),
      .LED(led_a), .STATE(st_a), .BOOT_O(boot_a), .SEL_O(sel_a)
   );

   blink_boot_ctrl #(
      .NUM_CH(3), .LOG2DELAY(4), .BOOT_TOGGLES(0), .HOLD_CYCLES(8), .BOOT_IMAGE(2'b10)
   ) dut_b (
      .CLK(clk), .RST(rst), .EN_CH(en_ch), .BOOT_REQ(boot_req),
      .LED(led_b), .STATE(st_b), .BOOT_O(boot_b), .SEL_O(sel_b)
   );

   typedef struct {
      bit         rst_first;
      bit         sel;       // 0: dut_a (BOOT_TOGGLES=5), 1: dut_b (BOOT_TOGGLES=0)
      int         edge_no;
      logic [2:0] en;
      logic       breq;
      logic [2:0] led;
      logic [1:0] st;
      logic       boot;
   } vec_t;

   typedef struct {
      int         edge_no;
      bit         sel;
      logic [2:0] led;
      logic [1:0] st;
      logic       boot;
      int         idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   task automatic check_dut(input string name, input bit sel, input logic [2:0] led,
                            input logic [1:0] st, input logic boot);
      logic [2:0] al;
      logic [1:0] ast, asel;
      logic       ab;
      al   = sel ? led_b  : led_a;
      ast  = sel ? st_b   : st_a;
      ab   = sel ? boot_b : boot_a;
      asel = sel ? sel_b  : sel_a;
      n_checks++;
      if ({al, ast, ab, asel} !== {led, st, boot, SEL_EXP}) begin
         n_err++;
         $display("FAIL %s dut=%0d edge=%0d got led=%b state=%0d boot=%b sel=%b want led=%b state=%0d boot=%b sel=%b",
                  name, sel, edge_n, al, ast, ab, asel, led, st, boot, SEL_EXP);
      end
   endtask

   // Scoreboard: pop the pending expectation once its edge has passed.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() > 0 && sb_q[0].edge_no == edge_n) begin
         e = sb_q.pop_front();
         check_dut($sformatf("vec%0d", e.idx), e.sel, e.led, e.st, e.boot);
      end
   end

   task automatic add(input bit r, input bit s, input int e, input logic [2:0] en,
                      input logic bq, input logic [2:0] l, input logic [1:0] st, input logic b);
      vecs.push_back(vec_t'{r, s, e, en, bq, l, st, b});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      boot_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive v.en/v.breq so they are sampled at edge v.edge_no, expect outputs after it.
   task automatic apply_vec(input vec_t v, input int idx);
      int k;
      k = 0;
      if (edge_n >= v.edge_no) begin
         n_checks++;
         n_err++;
         $display("FAIL vec%0d schedule got edge=%0d want below %0d", idx, edge_n, v.edge_no);
         return;
      end
      while (edge_n < v.edge_no - 1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) begin
         n_checks++;
         n_err++;
         $display("FAIL vec%0d wait got edge=%0d want %0d", idx, edge_n, v.edge_no - 1);
         return;
      end
      en_ch    = v.en;
      boot_req = v.breq;
      sb_q.push_back(exp_t'{v.edge_no, v.sel, v.led, v.st, v.boot, idx});
      @(posedge clk);
      #1;
      boot_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got edge=%0d want completion", edge_n);
      $fatal(1);
   end

   initial begin
      // rst, dut, edge, en, breq, led, state, boot
      // Blink rates with auto-boot disabled, plus a long run that must stay in RUN.
      add(1, 1,    1, 3'b111, 0, 3'b000, 2'd0, 0);
      add(0, 1,   15, 3'b111, 0, 3'b000, 2'd0, 0);
      add(0, 1,   16, 3'b111, 0, 3'b001, 2'd0, 0);
      add(0, 1,   31, 3'b111, 0, 3'b001, 2'd0, 0);
      add(0, 1,   32, 3'b111, 0, 3'b010, 2'd0, 0);
      add(0, 1,   47, 3'b111, 0, 3'b010, 2'd0, 0);
      add(0, 1,   48, 3'b111, 0, 3'b111, 2'd0, 0);
      add(0, 1,   64, 3'b111, 0, 3'b100, 2'd0, 0);
      add(0, 1,   80, 3'b111, 0, 3'b101, 2'd0, 0);
      add(0, 1,   96, 3'b111, 0, 3'b010, 2'd0, 0);
      add(0, 1, 2000, 3'b111, 0, 3'b101, 2'd0, 0);
      // Auto-boot after the 5th tick; BOOT_REQ in BOOT has no effect.
      add(1, 0,   15, 3'b111, 0, 3'b000, 2'd0, 0);
      add(0, 0,   16, 3'b111, 0, 3'b001, 2'd0, 0);
      add(0, 0,   48, 3'b111, 0, 3'b111, 2'd0, 0);
      add(0, 0,   64, 3'b111, 0, 3'b100, 2'd0, 0);
      add(0, 0,   79, 3'b111, 0, 3'b100, 2'd0, 0);
      add(0, 0,   80, 3'b111, 0, 3'b111, 2'd1, 0);
      add(0, 0,   87, 3'b111, 0, 3'b111, 2'd1, 0);
      add(0, 0,   88, 3'b111, 0, 3'b000, 2'd2, 1);
      add(0, 0,  100, 3'b111, 0, 3'b000, 2'd2, 1);
      add(0, 0,  101, 3'b111, 1, 3'b000, 2'd2, 1);
      // Early BOOT_REQ; requests and disables during HOLD are ignored.
      add(1, 0,   19, 3'b111, 0, 3'b001, 2'd0, 0);
      add(0, 0,   20, 3'b111, 1, 3'b111, 2'd1, 0);
      add(0, 0,   24, 3'b111, 1, 3'b111, 2'd1, 0);
      add(0, 0,   25, 3'b000, 0, 3'b111, 2'd1, 0);
      add(0, 0,   27, 3'b111, 0, 3'b111, 2'd1, 0);
      add(0, 0,   28, 3'b111, 0, 3'b000, 2'd2, 1);
      // BOOT_REQ coinciding with the 5th tick: one HOLD entry.
      add(1, 0,   79, 3'b111, 0, 3'b100, 2'd0, 0);
      add(0, 0,   80, 3'b111, 1, 3'b111, 2'd1, 0);
      add(0, 0,   87, 3'b111, 0, 3'b111, 2'd1, 0);
      add(0, 0,   88, 3'b111, 0, 3'b000, 2'd2, 1);
      // Channel 1 disabled at 40, re-enabled at 50, restarts from phase 0.
      add(1, 1,   39, 3'b111, 0, 3'b010, 2'd0, 0);
      add(0, 1,   40, 3'b101, 0, 3'b000, 2'd0, 0);
      add(0, 1,   48, 3'b101, 0, 3'b101, 2'd0, 0);
      add(0, 1,   50, 3'b111, 0, 3'b101, 2'd0, 0);
      add(0, 1,   64, 3'b111, 0, 3'b100, 2'd0, 0);
      add(0, 1,   79, 3'b111, 0, 3'b100, 2'd0, 0);
      add(0, 1,   80, 3'b111, 0, 3'b111, 2'd0, 0);
      add(0, 1,   96, 3'b111, 0, 3'b010, 2'd0, 0);

      rst      = 1'b1;
      en_ch    = 3'b111;
      boot_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_dut("reset_a", 0, 3'b000, 2'd0, 1'b0);
      check_dut("reset_b", 1, 3'b000, 2'd0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst_first) do_reset();
         apply_vec(vecs[i], i);
      end

      // Reset sampled at edge 84 while in HOLD, then auto-boot again from scratch.
      do_reset();
      apply_vec(vec_t'{1'b0, 1'b0, 83, 3'b111, 1'b0, 3'b111, 2'd1, 1'b0}, 100);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_dut("rst_in_hold", 0, 3'b000, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      apply_vec(vec_t'{1'b0, 1'b0, 79, 3'b111, 1'b0, 3'b100, 2'd0, 1'b0}, 101);
      apply_vec(vec_t'{1'b0, 1'b0, 80, 3'b111, 1'b0, 3'b111, 2'd1, 1'b0}, 102);
      apply_vec(vec_t'{1'b0, 1'b0, 88, 3'b111, 1'b0, 3'b000, 2'd2, 1'b1}, 103);

      // Reset from the terminal BOOT state.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_dut("rst_in_boot", 0, 3'b000, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      repeat (2) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got pending=%0d want 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
